sha256_rr_arbiter: RTL and testbench
====================================

Name: sha256_rr_arbiter

Overview:
- Shares one single-block SHA-256 engine between NUM_REQ requesters using round-robin arbitration.
- Each requester presents a pre-padded block as words w0..w14 plus a bit length. The engine computes w15 from the size.
- The arbiter latches the winning block, drives the engine's parallel interface and waits for the hash. It returns the hash with the requester ID on an AXI-Stream-style response channel.
- A watchdog and a size check produce error responses.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ
- TIMEOUT_CYCLES, 256, maximum cycles in WAIT before a timeout error

Ports:
- m_axis_aclk  in  1  clock
- m_axis_reset  in  1  synchronous reset, active-high
- s_req_valid  in  NUM_REQ  request valid, one bit per requester
- s_req_ready  out  NUM_REQ  request accepted; combinational one-hot
- s_req_block  in  NUM_REQ*480  15 words per requester; requester i occupies [i*480 +: 480], w0 in the low 32 bits
- s_req_size  in  NUM_REQ*8  message length in bits; requester i occupies [i*8 +: 8]
- eng_block  out  480  latched words to the engine (string_w0..w14)
- eng_size  out  8  latched size to the engine
- eng_dv  out  1  start strobe to the engine
- eng_ready  in  1  engine idle and able to accept a start
- eng_hash_dv  in  1  engine hash valid, one-cycle pulse
- eng_hash  in  256  engine hash
- m_rsp_valid  out  1  response valid
- m_rsp_ready  in  1  response accepted
- m_rsp_data  out  256  hash; zero on error
- m_rsp_id  out  ID_W  index of the requester served
- m_rsp_err  out  1  1 = size error or timeout
- busy  out  1  state != IDLE
- done_count  out  16  count of completed responses; wraps at 0xFFFF->0

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, all outputs 0 (s_req_ready=0, eng_dv=0, m_rsp_valid=0, done_count=0), latched block/size/hash cleared.
- Reset asserted mid-operation aborts the operation:
  - returns to IDLE next edge;
  - any hash arriving afterwards is ignored.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on a size error.
- IDLE, winner selection:
  - Winner = first i with s_req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - s_req_ready[winner] = 1 combinationally in IDLE only; all other bits are 0.
- IDLE, on the transfer edge:
  - latch the winner's block, size and ID;
  - rr_ptr <= (winner+1) mod NUM_REQ.
- IDLE, next state:
  - size[2:0] != 0 or size == 0 -> RESP with err=1 and hash=0; the engine is never started;
  - otherwise -> ISSUE.
- ISSUE:
  - eng_dv = 1 while in ISSUE;
  - on an edge with eng_ready=1 -> WAIT and clear the watchdog;
  - eng_dv is held across cycles where eng_ready=0.
- eng_block/eng_size hold the latched values continuously from latch until the next grant.
- WAIT:
  - watchdog increments each cycle;
  - eng_hash_dv=1 -> capture eng_hash, err=0, go to RESP;
  - watchdog == TIMEOUT_CYCLES-1 with no hash -> err=1, hash=0, go to RESP;
  - if both occur on the same edge, the hash wins.
- eng_hash_dv outside WAIT is ignored.
- RESP:
  - m_rsp_valid=1, with data/id/err stable until the handshake;
  - on m_rsp_valid & m_rsp_ready -> done_count+1 (including error responses), go to IDLE.
- A new grant is possible in the same cycle IDLE is re-entered.
- Latency: grant edge to eng_dv is 1 cycle. eng_hash_dv to m_rsp_valid is 1 cycle.
- Requesters withdrawing valid before ready are simply not granted; the arbiter keeps no memory of unserved requests.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0.

Test Plan:
- Reset, then requester 1 sends block w0..w3=686f6c61,20636172,61636f6c,61800000 (rest 0), size 104.
  - Engine model returns hash 256'hA5A5...A5 three cycles after eng_dv.
  - Required: eng_block/eng_size match the request; m_rsp_data=A5..A5, id=1, err=0; done_count=1.
- All four requesters valid continuously with distinct blocks:
  - required grant order 0,1,2,3,0;
  - each response id matches the block tagged in the engine model.
- Requester 2 sends size 13 (not byte-aligned):
  - eng_dv never asserts;
  - response id=2, err=1, data=0, one cycle after the grant.
- Engine model never pulses eng_hash_dv, TIMEOUT_CYCLES=16:
  - m_rsp_valid rises exactly 16 cycles after entering WAIT, with err=1 and data=0.
- eng_ready held 0 for 5 cycles in ISSUE:
  - eng_dv stays 1 with a stable eng_block;
  - WAIT is entered only on the edge after eng_ready rises.
- m_rsp_ready held 0 for 10 cycles:
  - response fields stay stable, s_req_ready stays 0 and busy=1.
- m_axis_reset pulsed during WAIT:
  - all outputs return to 0 next cycle;
  - a late eng_hash_dv produces no response.

Source files
------------

// File: rtl/sha256_rr_arbiter_if.sv
// Bundle of the request, engine and response channels around the SHA-256 arbiter.
// slave  : the arbiter's view (takes requests, drives engine and responses)
// master : the surrounding environment's view
interface sha256_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     s_req_valid;
    logic [NUM_REQ-1:0]     s_req_ready;
    logic [NUM_REQ*480-1:0] s_req_block;
    logic [NUM_REQ*8-1:0]   s_req_size;

    logic [479:0]           eng_block;
    logic [7:0]             eng_size;
    logic                   eng_dv;
    logic                   eng_ready;
    logic                   eng_hash_dv;
    logic [255:0]           eng_hash;

    logic                   m_rsp_valid;
    logic                   m_rsp_ready;
    logic [255:0]           m_rsp_data;
    logic [ID_W-1:0]        m_rsp_id;
    logic                   m_rsp_err;

    modport slave (
        input  s_req_valid, s_req_block, s_req_size,
        input  eng_ready, eng_hash_dv, eng_hash,
        input  m_rsp_ready,
        output s_req_ready,
        output eng_block, eng_size, eng_dv,
        output m_rsp_valid, m_rsp_data, m_rsp_id, m_rsp_err
    );

    modport master (
        output s_req_valid, s_req_block, s_req_size,
        output eng_ready, eng_hash_dv, eng_hash,
        output m_rsp_ready,
        input  s_req_ready,
        input  eng_block, eng_size, eng_dv,
        input  m_rsp_valid, m_rsp_data, m_rsp_id, m_rsp_err
    );
endinterface

// File: rtl/sha256_rr_arbiter.sv
// Round-robin front end sharing one single-block SHA-256 engine between
// NUM_REQ requesters. Latches the winning block, starts the engine, waits for
// the hash (with a watchdog) and returns it tagged with the requester ID.
// Blocks whose bit length is zero or not byte-aligned are answered with an
// error response without ever touching the engine.
module sha256_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               m_axis_aclk,
    input  logic               m_axis_reset,
    sha256_rr_arbiter_if.slave bus,
    output logic               busy,
    output logic [15:0]        done_count
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic            grant;
    logic            sz_bad;
    logic            wd_expired;
    logic [479:0]    win_block;
    logic [7:0]      win_size;

    logic [479:0]    blk_q;
    logic [7:0]      size_q;
    logic [ID_W-1:0] id_q;
    logic [255:0]    hash_q;
    logic            err_q;
    logic [WD_W-1:0] wdog;

    // Rotating-priority search: first valid requester at or after rr_ptr
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && bus.s_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign win_block  = bus.s_req_block[int'(win_idx)*480 +: 480];
    assign win_size   = bus.s_req_size[int'(win_idx)*8 +: 8];
    // A grant while reset is held would be discarded, so it is not offered
    assign grant      = (state_q == S_IDLE) && win_found && !m_axis_reset;
    assign sz_bad     = (win_size[2:0] != 3'b000) || (win_size == 8'd0);
    assign wd_expired = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_reset) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d         = state_q;
        bus.s_req_ready = '0;
        bus.eng_dv      = 1'b0;
        bus.m_rsp_valid = 1'b0;
        busy            = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    for (int i = 0; i < NUM_REQ; i++)
                        bus.s_req_ready[i] = (win_idx == ID_W'(i));
                    state_d = sz_bad ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.eng_dv = 1'b1;
                if (bus.eng_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.eng_hash_dv || wd_expired) state_d = S_RESP;
            end
            S_RESP: begin
                bus.m_rsp_valid = 1'b1;
                if (bus.m_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latched request, watchdog, captured hash and completion counter
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_reset) begin
            rr_ptr     <= '0;
            blk_q      <= '0;
            size_q     <= '0;
            id_q       <= '0;
            hash_q     <= '0;
            err_q      <= 1'b0;
            wdog       <= '0;
            done_count <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        blk_q  <= win_block;
                        size_q <= win_size;
                        id_q   <= win_idx;
                        hash_q <= '0;
                        err_q  <= sz_bad;
                        rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.eng_ready) wdog <= '0;
                end
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // a hash landing on the timeout edge still counts as success
                    if (bus.eng_hash_dv) begin
                        hash_q <= bus.eng_hash;
                        err_q  <= 1'b0;
                    end else if (wd_expired) begin
                        hash_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.m_rsp_ready) done_count <= done_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.eng_block  = blk_q;
    assign bus.eng_size   = size_q;
    assign bus.m_rsp_data = hash_q;
    assign bus.m_rsp_id   = id_q;
    assign bus.m_rsp_err  = err_q;

endmodule

// File: tb/tb_sha256_rr_arbiter.sv
// Bench for sha256_rr_arbiter: directed scenarios plus randomized
// transactions, checked against a transaction-level reference (rotating
// winner search, size rule, fixed engine latency / watchdog length).
module tb_sha256_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TMO     = 16;
    localparam int ELAT    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] done_count;

    always #5 clk = ~clk;

    sha256_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    sha256_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO)) dut (
        .m_axis_aclk (clk),
        .m_axis_reset(rst),
        .bus         (bus),
        .busy        (busy),
        .done_count  (done_count)
    );

    // requester side storage
    logic [479:0] blk [NUM_REQ];
    logic [7:0]   sz  [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.s_req_block[i*480 +: 480] = blk[i];
            bus.s_req_size[i*8 +: 8]      = sz[i];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int ref_ptr  = 0;
    int ref_done = 0;

    task automatic chk(input string tag, input logic [479:0] got, input logic [479:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mkhash(input logic [479:0] b);
        return b[255:0] ^ {8{32'h9e3779b9}};
    endfunction

    function automatic int ref_winner(input logic [NUM_REQ-1:0] vm);
        for (int k = 0; k < NUM_REQ; k++)
            if (vm[(ref_ptr + k) % NUM_REQ]) return (ref_ptr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int w);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    // engine model: fixed latency after the start handshake, or silent
    bit           eng_mute = 1'b0;
    bit           eng_a5   = 1'b0;
    int           eng_cnt  = 0;
    int           dv_cycles = 0;
    logic [255:0] pend;

    initial begin
        bus.eng_hash_dv = 1'b0;
        bus.eng_hash    = '0;
        pend            = '0;
        forever begin
            @(posedge clk);
            #3;
            bus.eng_hash_dv = 1'b0;
            if (bus.eng_dv) dv_cycles++;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.eng_hash_dv = 1'b1;
                    bus.eng_hash    = pend;
                end
            end
            if (bus.eng_dv && bus.eng_ready && !eng_mute) begin
                eng_cnt = ELAT;
                pend    = eng_a5 ? {32{8'hA5}} : mkhash(bus.eng_block);
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, bus.s_req_ready, '0);
        chk({tag, "_eng_dv"}, bus.eng_dv, 0);
        chk({tag, "_rsp_valid"}, bus.m_rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done_count, 0);
        chk({tag, "_eng_block"}, bus.eng_block, '0);
        chk({tag, "_eng_size"}, bus.eng_size, 0);
        chk({tag, "_rsp_data"}, bus.m_rsp_data, '0);
        chk({tag, "_rsp_err"}, bus.m_rsp_err, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ref_ptr  = 0;
        ref_done = 0;
    endtask

    // One full request/response transaction with the given valid mask,
    // engine-ready stall length and response back-pressure length.
    task automatic do_txn(input logic [NUM_REQ-1:0] vm, input int stall, input int hold,
                          output int got_id);
        int           w, n, dv0;
        bit           bad, ee;
        logic [255:0] ed;
        w   = ref_winner(vm);
        bad = (sz[w][2:0] != 3'b000) || (sz[w] == 8'd0);
        ee  = bad || eng_mute;
        ed  = ee ? '0 : (eng_a5 ? {32{8'hA5}} : mkhash(blk[w]));
        bus.eng_ready   = (stall == 0);
        bus.s_req_valid = vm;
        dv0 = dv_cycles;
        #1;
        chk("grant", bus.s_req_ready, onehot(w));
        step();
        ref_ptr = (w + 1) % NUM_REQ;
        if (bad) begin
            chk("err_rsp_1cyc", bus.m_rsp_valid, 1);
            chk("err_no_dv", bus.eng_dv, 0);
        end else begin
            chk("eng_dv", bus.eng_dv, 1);
            chk("eng_block", bus.eng_block, blk[w]);
            chk("eng_size", bus.eng_size, sz[w]);
            for (int i = 0; i < stall; i++) begin
                step();
                chk("stall_dv", bus.eng_dv, 1);
                chk("stall_blk", bus.eng_block, blk[w]);
            end
            bus.eng_ready = 1'b1;
            step();
            chk("wait_entry", bus.eng_dv, 0);
            n = 0;
            while (!bus.m_rsp_valid && n < 2 * TMO) begin
                step();
                n++;
            end
            chk("rsp_lat", n, eng_mute ? TMO : ELAT);
        end
        chk("rsp_valid", bus.m_rsp_valid, 1);
        chk("rsp_id", bus.m_rsp_id, w);
        chk("rsp_err", bus.m_rsp_err, ee);
        chk("rsp_data", bus.m_rsp_data, ed);
        got_id = int'(bus.m_rsp_id);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", bus.m_rsp_valid, 1);
            chk("hold_data", bus.m_rsp_data, ed);
            chk("hold_id", bus.m_rsp_id, w);
            chk("hold_err", bus.m_rsp_err, ee);
            chk("hold_ready", bus.s_req_ready, '0);
            chk("hold_busy", busy, 1);
        end
        bus.m_rsp_ready = 1'b1;
        step();
        bus.m_rsp_ready = 1'b0;
        ref_done++;
        chk("done_cnt", done_count, ref_done[15:0]);
        chk("rsp_drop", bus.m_rsp_valid, 0);
        chk("dv_cycles", dv_cycles - dv0, bad ? 0 : stall + 1);
        bus.s_req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int id;
        rst             = 1'b1;
        bus.s_req_valid = '0;
        bus.eng_ready   = 1'b1;
        bus.m_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            blk[i] = '0;
            sz[i]  = '0;
        end
        repeat (3) step();
        chk_quiet("reset");
        rst = 1'b0;
        step();

        // known block from requester 1, engine answers A5..A5
        blk[1][31:0]   = 32'h686f6c61;
        blk[1][63:32]  = 32'h20636172;
        blk[1][95:64]  = 32'h61636f6c;
        blk[1][127:96] = 32'h61800000;
        sz[1]  = 8'd104;
        eng_a5 = 1'b1;
        do_txn(4'b0010, 0, 0, id);
        eng_a5 = 1'b0;

        // fairness with everyone valid
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < 15; k++) blk[i][k*32 +: 32] = $urandom;
            blk[i][7:0] = 8'(i);
            sz[i]       = 8'd64;
        end
        for (int t = 0; t < 5; t++) begin
            do_txn(4'b1111, 0, 0, id);
            chk("rr_order", id, t % NUM_REQ);
        end

        // size not byte-aligned
        sz[2] = 8'd13;
        do_txn(4'b0100, 0, 0, id);
        sz[2] = 8'd0;
        do_txn(4'b0100, 0, 0, id);
        sz[2] = 8'd64;

        // engine silent -> watchdog
        eng_mute = 1'b1;
        do_txn(4'b0001, 0, 0, id);
        eng_mute = 1'b0;

        // engine not ready for 5 cycles, then response back-pressure
        do_txn(4'b0010, 5, 0, id);
        do_txn(4'b1000, 0, 10, id);

        // reset during WAIT; the late hash must be dropped
        bus.s_req_valid = 4'b0001;
        bus.eng_ready   = 1'b1;
        step();
        bus.s_req_valid = '0;
        step();
        chk("rst_pre_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_ptr  = 0;
        ref_done = 0;
        chk_quiet("midrst");
        for (int i = 0; i < 8; i++) begin
            step();
            chk("late_hash_rsp", bus.m_rsp_valid, 0);
            chk("late_hash_busy", busy, 0);
        end

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [NUM_REQ-1:0] vm;
            vm = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int k = 0; k < 15; k++) blk[i][k*32 +: 32] = $urandom;
                if ($urandom_range(0, 3) == 0) sz[i] = 8'($urandom);
                else                           sz[i] = {5'($urandom), 3'b000};
            end
            eng_mute = ($urandom_range(0, 7) == 0);
            do_txn(vm, $urandom_range(0, 2), $urandom_range(0, 2), id);
            eng_mute = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
